// File: rtl/sdram_refresh_sched.sv
// SDRAM auto-refresh scheduler: accrues refresh debt every tREFI, requests the bus from the
// arbiter, and on grant issues an optional PRECHARGE-ALL followed by a REFRESH burst that clears the debt.
module sdram_refresh_sched #(
  parameter int T_REFI_CYC   = 780,
  parameter int T_RFC_CYC    = 7,
  parameter int T_RP_CYC     = 2,
  parameter int PRECHARGE_EN = 1,
  parameter int MAX_OWED     = 8,
  parameter int URGENT_LVL   = 6,
  parameter int ADDR_W       = 13,
  localparam int OWED_W      = $clog2(MAX_OWED + 1)
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic              refresh_en,
  input  logic              arbit_refresh_ack,
  output logic              arbit_refresh_req,
  output logic              refresh_urgent,
  output logic              refresh_end,
  output logic [3:0]        cmd_reg,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [OWED_W-1:0] owed_cnt,
  output logic              overflow_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_TRP,
    S_REF,
    S_TRFC,
    S_DONE
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  localparam int TIMER_W  = $clog2(T_REFI_CYC);
  localparam int WAIT_MAX = (T_RFC_CYC > T_RP_CYC) ? T_RFC_CYC : T_RP_CYC;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(T_REFI_CYC - 1);
  localparam logic [OWED_W-1:0]  OWED_MAX   = OWED_W'(MAX_OWED);
  localparam logic [OWED_W-1:0]  OWED_URG   = OWED_W'(URGENT_LVL);
  localparam logic [WAIT_W-1:0]  TRP_LOAD   = WAIT_W'(T_RP_CYC - 1);
  localparam logic [WAIT_W-1:0]  TRFC_LOAD  = WAIT_W'(T_RFC_CYC - 2);

  state_t              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [OWED_W-1:0]   owed_q, owed_d;
  logic                overflow_q, overflow_d;
  logic                urgent_q, urgent_d;
  logic                req_q, req_d;
  logic                end_q, end_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                tick;
  logic                refresh_now;

  // A REFRESH is on the bus exactly while the FSM sits in S_REF, since outputs follow state_q.
  assign refresh_now = (state_q == S_REF);

  always_comb begin
    timer_d = timer_q;
    tick    = 1'b0;
    if (refresh_en) begin
      if (timer_q == TIMER_LAST) begin
        timer_d = '0;
        tick    = 1'b1;
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end
  end

  always_comb begin
    owed_d = owed_q;
    if (tick && !refresh_now) begin
      if (owed_q != OWED_MAX) begin
        owed_d = owed_q + OWED_W'(1);
      end
    end else if (!tick && refresh_now) begin
      owed_d = owed_q - OWED_W'(1);
    end
    overflow_d = overflow_q | (tick && (owed_q == OWED_MAX));
    urgent_d   = (owed_d >= OWED_URG);
  end

  // Outputs are decoded from the next state so the registered command lines up with state_q.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE: begin
        if (req_q && arbit_refresh_ack) begin
          state_d = (PRECHARGE_EN != 0) ? S_PRE : S_REF;
        end
      end
      S_PRE: begin
        state_d = S_TRP;
        wait_d  = TRP_LOAD;
      end
      S_TRP: begin
        if (wait_q == '0) begin
          state_d = S_REF;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_REF: begin
        state_d = S_TRFC;
        wait_d  = TRFC_LOAD;
      end
      S_TRFC: begin
        if (wait_q == '0) begin
          state_d = (owed_d != '0) ? S_REF : S_DONE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_d  = CMD_NOP;
    addr_d = '0;
    end_d  = 1'b0;
    req_d  = 1'b0;
    case (state_d)
      S_PRE: begin
        cmd_d      = CMD_PRE;
        addr_d[10] = 1'b1;
      end
      S_REF: begin
        cmd_d = CMD_REF;
      end
      S_DONE: begin
        end_d = 1'b1;
      end
      S_IDLE: begin
        req_d = (state_q == S_IDLE) && (owed_q != '0);
      end
      default: begin
        cmd_d = CMD_NOP;
      end
    endcase
  end

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      wait_q     <= '0;
      owed_q     <= '0;
      overflow_q <= 1'b0;
      urgent_q   <= 1'b0;
      req_q      <= 1'b0;
      end_q      <= 1'b0;
      cmd_q      <= CMD_NOP;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wait_q     <= wait_d;
      owed_q     <= owed_d;
      overflow_q <= overflow_d;
      urgent_q   <= urgent_d;
      req_q      <= req_d;
      end_q      <= end_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
    end
  end

  assign arbit_refresh_req = req_q;
  assign refresh_urgent    = urgent_q;
  assign refresh_end       = end_q;
  assign cmd_reg           = cmd_q;
  assign sdram_addr        = addr_q;
  assign owed_cnt          = owed_q;
  assign overflow_err      = overflow_q;

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Directed bench for sdram_refresh_sched with default parameters: a vector table for the single
// refresh burst plus hand-timed sequences for debt build-up, saturation, tick/REFRESH collision and reset.
module tb_sdram_refresh_sched;

  localparam int ADDR_W = 13;
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              refresh_en = 1'b0;
  logic              ack = 1'b0;
  logic              req;
  logic              urgent;
  logic              rend;
  logic [3:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        owed;
  logic              ovf;

  int cyc;
  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic       ack;
    logic [3:0] cmd;
    logic       addr10;
    logic       req;
    logic       rend;
    logic [3:0] owed;
  } vec_t;

  vec_t t2_vecs[12];

  sdram_refresh_sched dut (
    .sysclk_100M       (clk),
    .rst_n             (rst_n),
    .refresh_en        (refresh_en),
    .arbit_refresh_ack (ack),
    .arbit_refresh_req (req),
    .refresh_urgent    (urgent),
    .refresh_end       (rend),
    .cmd_reg           (cmd),
    .sdram_addr        (addr),
    .owed_cnt          (owed),
    .overflow_err      (ovf)
  );

  always #5 clk = ~clk;

  // Cycle count since the last reset release, used to time every check against the tREFI grid.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ack_val);
    ack = ack_val;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    if (cyc > target) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL run_to: already at cycle %0d, wanted %0d", cyc, target);
    end
    while (cyc < target) @(negedge clk);
  endtask

  task automatic monitor_burst(input int budget, output int refs, output int first_ref,
                               output int last_ref, output int end_at, output int bad_gap);
    refs = 0; first_ref = -1; last_ref = -1; end_at = -1; bad_gap = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd == REF) begin
        if (refs > 0 && (cyc - last_ref) != 7) bad_gap++;
        if (refs == 0) first_ref = cyc;
        last_ref = cyc;
        refs++;
      end
      if (rend) begin
        end_at = cyc;
        break;
      end
    end
  endtask

  task automatic do_t1();
    rst_n = 1'b1;
    refresh_en = 1'b1;
    repeat (779) @(negedge clk);
    checkOutput("t1_owed_before_tick", int'(owed), 0);
    checkOutput("t1_req_before_tick", int'(req), 0);
    @(negedge clk);
    checkOutput("t1_owed_after_tick", int'(owed), 1);
    checkOutput("t1_req_lags_owed", int'(req), 0);
    @(negedge clk);
    checkOutput("t1_req_raised", int'(req), 1);
    checkOutput("t1_owed_held", int'(owed), 1);
  endtask

  initial begin
    int refs, first_ref, last_ref, end_at, bad_gap;

    t2_vecs[0] = '{1'b1, PRE, 1'b1, 1'b0, 1'b0, 4'd1};
    t2_vecs[1] = '{1'b0, NOP, 1'b0, 1'b0, 1'b0, 4'd1};
    t2_vecs[2] = '{1'b0, NOP, 1'b0, 1'b0, 1'b0, 4'd1};
    t2_vecs[3] = '{1'b0, REF, 1'b0, 1'b0, 1'b0, 4'd1};
    for (int i = 4; i < 10; i++) t2_vecs[i] = '{1'b0, NOP, 1'b0, 1'b0, 1'b0, 4'd0};
    t2_vecs[10] = '{1'b0, NOP, 1'b0, 1'b0, 1'b1, 4'd0};
    t2_vecs[11] = '{1'b0, NOP, 1'b0, 1'b0, 1'b0, 4'd0};

    repeat (3) @(negedge clk);
    checkOutput("rst_cmd", int'(cmd), int'(NOP));
    checkOutput("rst_addr", int'(addr), 0);
    checkOutput("rst_owed", int'(owed), 0);
    checkOutput("rst_req", int'(req), 0);
    checkOutput("rst_end", int'(rend), 0);
    checkOutput("rst_urgent", int'(urgent), 0);
    checkOutput("rst_ovf", int'(ovf), 0);

    do_t1();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(t2_vecs[i].ack);
      checkOutput($sformatf("t2_cmd[%0d]", i), int'(cmd), int'(t2_vecs[i].cmd));
      checkOutput($sformatf("t2_addr10[%0d]", i), int'(addr[10]), int'(t2_vecs[i].addr10));
      checkOutput($sformatf("t2_req[%0d]", i), int'(req), int'(t2_vecs[i].req));
      checkOutput($sformatf("t2_end[%0d]", i), int'(rend), int'(t2_vecs[i].rend));
      checkOutput($sformatf("t2_owed[%0d]", i), int'(owed), int'(t2_vecs[i].owed));
    end

    run_to(3119);
    checkOutput("t3_owed_2", int'(owed), 2);
    run_to(3120);
    checkOutput("t3_owed_3", int'(owed), 3);
    checkOutput("t3_req", int'(req), 1);
    ack = 1'b1;
    monitor_burst(60, refs, first_ref, last_ref, end_at, bad_gap);
    ack = 1'b0;
    checkOutput("t3_refs", refs, 3);
    checkOutput("t3_first_ref", first_ref, 3124);
    checkOutput("t3_last_ref", last_ref, 3138);
    checkOutput("t3_gap_errors", bad_gap, 0);
    checkOutput("t3_end_cycle", end_at, 3145);
    checkOutput("t3_owed_cleared", int'(owed), 0);
    @(negedge clk);
    checkOutput("t3_end_single", int'(rend), 0);
    checkOutput("t3_req_after", int'(req), 0);

    run_to(7799);
    checkOutput("t4_owed_5", int'(owed), 5);
    checkOutput("t4_urgent_low", int'(urgent), 0);
    run_to(7800);
    checkOutput("t4_owed_6", int'(owed), 6);
    checkOutput("t4_urgent_high", int'(urgent), 1);
    run_to(9360);
    checkOutput("t4_owed_8", int'(owed), 8);
    run_to(10139);
    checkOutput("t4_ovf_before", int'(ovf), 0);
    checkOutput("t4_owed_sat", int'(owed), 8);
    run_to(10140);
    checkOutput("t4_ovf_set", int'(ovf), 1);
    checkOutput("t4_owed_still_8", int'(owed), 8);
    ack = 1'b1;
    monitor_burst(100, refs, first_ref, last_ref, end_at, bad_gap);
    ack = 1'b0;
    checkOutput("t4_refs", refs, 8);
    checkOutput("t4_first_ref", first_ref, 10144);
    checkOutput("t4_last_ref", last_ref, 10193);
    checkOutput("t4_gap_errors", bad_gap, 0);
    checkOutput("t4_end_cycle", end_at, 10200);
    checkOutput("t4_owed_cleared", int'(owed), 0);
    checkOutput("t4_ovf_sticky", int'(ovf), 1);
    checkOutput("t4_urgent_cleared", int'(urgent), 0);

    run_to(11700);
    checkOutput("t5_owed_2", int'(owed), 2);
    run_to(12475);
    ack = 1'b1;
    run_to(12479);
    checkOutput("t5_ref_on_tick", int'(cmd), int'(REF));
    checkOutput("t5_owed_at_ref", int'(owed), 2);
    run_to(12480);
    checkOutput("t5_owed_unchanged", int'(owed), 2);
    ack = 1'b0;
    monitor_burst(60, refs, first_ref, last_ref, end_at, bad_gap);
    checkOutput("t5_more_refs", refs, 2);
    checkOutput("t5_second_ref", first_ref, 12486);
    checkOutput("t5_last_ref", last_ref, 12493);
    checkOutput("t5_gap_errors", bad_gap, 0);
    checkOutput("t5_end_cycle", end_at, 12500);
    checkOutput("t5_owed_cleared", int'(owed), 0);

    run_to(14040);
    checkOutput("t6_owed_2", int'(owed), 2);
    ack = 1'b1;
    run_to(14041);
    ack = 1'b0;
    run_to(14047);
    checkOutput("t6_trfc_nop", int'(cmd), int'(NOP));
    checkOutput("t6_owed_mid", int'(owed), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_cmd", int'(cmd), int'(NOP));
    checkOutput("t6_req", int'(req), 0);
    checkOutput("t6_end", int'(rend), 0);
    checkOutput("t6_owed", int'(owed), 0);
    checkOutput("t6_addr", int'(addr), 0);
    checkOutput("t6_ovf", int'(ovf), 0);
    checkOutput("t6_urgent", int'(urgent), 0);
    @(negedge clk);
    do_t1();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
